// File: rtl/dma_pkg.sv
// dma_pkg: shared state encoding, mode codes and descriptor widths for the descriptor scheduler
package dma_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
  localparam logic MODE_MEM_TO_CPU = 1'b0;
  localparam logic MODE_CPU_TO_MEM = 1'b1;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LEN_W = 32;
  function automatic int desc_w(input int addr_w, input int len_w);
    return addr_w + len_w + 1;
  endfunction
endpackage

// File: rtl/dma_desc_fifo.sv
// dma_desc_fifo: first-word-fall-through descriptor FIFO with occupancy count
module dma_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 65
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign rdata = mem[rp];
  // pointers wrap naturally at DEPTH; a push into a full FIFO is refused even when popping
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage needs no reset; only entries below the level are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end
endmodule

// File: rtl/dma_desc_scheduler.sv
// dma_desc_scheduler: queues CPU descriptors and issues them one at a time to the DMA address channel
module dma_desc_scheduler
  import dma_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     desc_valid,
  output logic                     desc_enable,
  input  logic [ADDR_W-1:0]        desc_addr,
  input  logic [LEN_W-1:0]         desc_len,
  input  logic                     desc_mode,
  output logic                     dma_addr_valid,
  input  logic                     dma_addr_enable,
  output logic [ADDR_W-1:0]        dma_addr,
  output logic [LEN_W-1:0]         dma_len,
  output logic                     dma_mode,
  input  logic                     byte_done,
  output logic                     busy,
  output logic                     done_pulse,
  output logic [7:0]               done_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int W = desc_w(ADDR_W, LEN_W);
  state_t state, state_n;
  logic [W-1:0] head;
  logic [ADDR_W-1:0] head_addr;
  logic [LEN_W-1:0] head_len;
  logic head_mode;
  logic [LEN_W-1:0] remaining;
  logic full, empty, pop;
  assign {head_addr, head_len, head_mode} = head;
  assign pop = state == IDLE && !empty;
  assign desc_enable = !full;
  assign dma_addr_valid = state == ISSUE;
  assign done_pulse = state == DONE;
  assign busy = state != IDLE || !empty;
  dma_desc_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (desc_valid),
    .pop    (pop),
    .wdata  ({desc_addr, desc_len, desc_mode}),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .level  (fifo_level)
  );
  // state register
  always_ff @(posedge clk) begin
    state <= !resetn ? IDLE : state_n;
  end
  // next state: zero-length descriptors skip the address phase and complete directly
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = empty ? IDLE : (head_len != '0 ? ISSUE : DONE);
      ISSUE: state_n = dma_addr_enable ? RUN : ISSUE;
      RUN:   state_n = byte_done && remaining == LEN_W'(1) ? DONE : RUN;
      DONE:  state_n = IDLE;
    endcase
  end
  // active descriptor, byte countdown and completion counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dma_addr <= '0;
      dma_len <= '0;
      dma_mode <= MODE_MEM_TO_CPU;
      remaining <= '0;
      done_count <= '0;
    end else begin
      if (pop) begin
        dma_addr <= head_addr;
        dma_len <= head_len;
        dma_mode <= head_mode;
      end
      if (state == ISSUE && dma_addr_enable) remaining <= dma_len;
      else if (state == RUN && byte_done) remaining <= remaining - LEN_W'(1);
      if (state_n == DONE) done_count <= done_count + 8'd1;
    end
  end
endmodule
